// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// fetch_pc_unit : owns the PC, sequences FETCH/WAIT/EXEC and computes next PC
// Rev 1.0
// ============================================================================
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] inst_encoding,
  output logic        inst_valid,
  input  logic [2:0]  next_pc_sel,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_data,
  input  logic        branch_taken,
  input  logic        retire_ready,
  output logic [31:0] pc,
  output logic [31:0] link_addr,
  output logic        misalign_trap,
  output logic [31:0] instret
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;

  localparam logic [2:0] C_PC_PLUS_4 = 3'd0;
  localparam logic [2:0] C_JAL_IMM   = 3'd1;
  localparam logic [2:0] C_FROM_RF   = 3'd2;
  localparam logic [2:0] C_BRCH_IMM  = 3'd3;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic        w_retire;
  logic [31:0] w_target;
  logic        w_misalign;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FETCH: if (imem_req_ready) w_state_nxt = S_WAIT;
      S_WAIT:  if (imem_rsp_valid) w_state_nxt = S_EXEC;
      S_EXEC:  if (retire_ready)   w_state_nxt = S_FETCH;
      default:                     w_state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    imem_req_valid = (r_state == S_FETCH);
    inst_valid     = (r_state == S_EXEC);
  end

  assign w_retire = (r_state == S_EXEC) && retire_ready;

  // Unknown selector codes fall through to sequential execution.
  always_comb begin
    w_target = pc + 32'd4;
    case (next_pc_sel)
      C_PC_PLUS_4: w_target = pc + 32'd4;
      C_JAL_IMM:   w_target = pc + imm;
      C_FROM_RF:   w_target = (rs1_data + imm) & 32'hFFFF_FFFE;
      C_BRCH_IMM:  w_target = branch_taken ? (pc + imm) : (pc + 32'd4);
      default:     w_target = pc + 32'd4;
    endcase
  end

  assign w_misalign = |w_target[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= RESET_PC;
      inst_encoding <= 32'h0;
      instret       <= 32'h0;
      misalign_trap <= 1'b0;
    end else begin
      misalign_trap <= 1'b0;
      if ((r_state == S_WAIT) && imem_rsp_valid)
        inst_encoding <= imem_rsp_data;
      if (w_retire) begin
        instret       <= instret + 32'd1;
        misalign_trap <= w_misalign;
        pc            <= w_misalign ? TRAP_PC : w_target;
      end
    end
  end

  assign imem_addr = pc;
  assign link_addr = pc + 32'd4;

endmodule
`default_nettype wire
